// File: rtl/starfield_ctrl_pkg.sv
// starfield_ctrl_pkg: register map, control bits and FSM states for starfield_speed_ctrl
package starfield_ctrl_pkg;
    localparam logic [1:0] REG_TARGET = 2'd0;
    localparam logic [1:0] REG_STEP   = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;
    localparam int CTRL_RAMP_EN = 0;
    typedef enum logic [1:0] {INIT, IDLE, RAMP, WRITE} state_t;
endpackage

// File: rtl/starfield_speed_ctrl_rise_detect.sv
// rise_detect: registered rising-edge detector producing a one-cycle tick
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic tick_r
);
    logic d_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q    <= 1'b0;
            tick_r <= 1'b0;
        end else begin
            d_q    <= d;
            tick_r <= d & ~d_q;
        end
    end
endmodule

// File: rtl/starfield_speed_ctrl.sv
// starfield_speed_ctrl: CPU-programmable, frame-paced speed ramp for the starfield generator
module starfield_speed_ctrl
    import starfield_ctrl_pkg::*;
#(
    parameter logic [7:0] DEFAULT_SPEED = 8'd1,
    parameter logic [7:0] DEFAULT_STEP  = 8'd1,
    parameter logic [7:0] DEFAULT_DIV   = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblank,
    input  logic       cpu_wr,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic [7:0] sf_data,
    output logic       sf_write,
    output logic       busy
);
    state_t state;
    logic [7:0] target, step, div, cur, fcnt;
    logic [7:0] step_eff, div_eff, target_nxt, stepped;
    logic [8:0] up;
    logic signed [8:0] dn;
    logic ramp_en, tick_r;

    rise_detect u_rise (.clk(clk), .rst(rst), .d(vblank), .tick_r(tick_r));

    assign step_eff   = (step == 8'd0) ? 8'd1 : step;
    assign div_eff    = (div == 8'd0) ? 8'd1 : div;
    assign up         = {1'b0, cur} + {1'b0, step_eff};
    assign dn         = $signed({1'b0, cur}) - $signed({1'b0, step_eff});
    // Both directions clamp at TARGET so the ramp never overshoots or wraps
    assign stepped    = (cur < target) ? ((up > {1'b0, target}) ? target : up[7:0]) :
                        (cur > target) ? ((dn < $signed({1'b0, target})) ? target : dn[7:0]) : cur;
    assign target_nxt = (cpu_wr && cpu_addr == REG_TARGET) ? cpu_wdata : target;
    assign cpu_rdata  = (cpu_addr == REG_TARGET) ? target :
                        (cpu_addr == REG_STEP)   ? step :
                        (cpu_addr == REG_DIV)    ? div : {7'b0, ramp_en};
    assign sf_data    = cur;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            target  <= DEFAULT_SPEED;
            step    <= DEFAULT_STEP;
            div     <= DEFAULT_DIV;
            ramp_en <= 1'b1;
        end else if (cpu_wr) begin
            if (cpu_addr == REG_TARGET) target <= cpu_wdata;
            if (cpu_addr == REG_STEP) step <= cpu_wdata;
            if (cpu_addr == REG_DIV) div <= cpu_wdata;
            if (cpu_addr == REG_CTRL) ramp_en <= cpu_wdata[CTRL_RAMP_EN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            cur      <= DEFAULT_SPEED;
            fcnt     <= 8'd0;
            sf_write <= 1'b0;
        end else begin
            sf_write <= 1'b0;
            case (state)
                INIT: begin
                    state    <= WRITE;
                    sf_write <= 1'b1;
                end
                IDLE: begin
                    fcnt <= 8'd0;
                    // Look at the incoming write so an immediate-mode update costs no extra cycle
                    if (target_nxt != cur) state <= RAMP;
                end
                RAMP: begin
                    if (!ramp_en) begin
                        cur      <= target;
                        state    <= WRITE;
                        sf_write <= 1'b1;
                    end else if (tick_r) begin
                        if (fcnt == div_eff - 8'd1) begin
                            fcnt     <= 8'd0;
                            cur      <= stepped;
                            state    <= WRITE;
                            sf_write <= 1'b1;
                        end else begin
                            fcnt <= fcnt + 8'd1;
                        end
                    end
                end
                WRITE: state <= (cur == target) ? IDLE : RAMP;
                default: state <= INIT;
            endcase
        end
    end
endmodule
